// File: rtl/pause_dim_ctrl.sv
// pause_dim_ctrl: merges user-button, OSD and external pause sources into one
// registered pause_cpu, and dims the RGB stream after a sustained user/OSD pause.
module pause_dim_ctrl #(
    parameter int RW        = 4,
    parameter int GW        = 4,
    parameter int BW        = 4,
    parameter int CLK_HZ    = 12_000_000,
    parameter int DIM_SECS  = 10,
    parameter int DIM_SHIFT = 1,
    parameter int NUM_REQ   = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic [NUM_REQ-1:0]    pause_request,
    input  logic [1:0]            options,
    input  logic                  OSD_STATUS,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  pause_cpu,
    output logic                  dim_video
);

    localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [7:0]      SEC_LIMIT  = 8'(DIM_SECS);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_DIMMED = 2'd2;

    logic                  btn_q,        btn_d;
    logic                  user_pause_q, user_pause_d;
    logic                  pause_cpu_q,  pause_cpu_d;
    logic                  dim_video_q,  dim_video_d;
    logic [1:0]            state_q,      state_d;
    logic [PW-1:0]         presc_q,      presc_d;
    logic [7:0]            sec_q,        sec_d;
    logic [RW+GW+BW-1:0]   rgb_q,        rgb_d;

    logic                  edge_s;
    logic                  soft_s;
    logic                  hard_s;
    logic                  wrap_s;

    // Pause source merge; soft uses the already-toggled user_pause.
    always_comb begin
        btn_d        = user_button;
        edge_s       = user_button & ~btn_q;
        user_pause_d = user_pause_q ^ edge_s;
        soft_s       = user_pause_d | (options[0] & OSD_STATUS);
        hard_s       = |pause_request;
        pause_cpu_d  = soft_s | hard_s;
    end

    // Pause/dim state machine with seconds prescaler.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        wrap_s  = (presc_q == PRESC_LAST);
        if (!soft_s) begin
            // A dropping soft pause beats any coincident prescaler wrap.
            state_d = ST_RUN;
            presc_d = {PW{1'b0}};
            sec_d   = 8'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    state_d = ST_PAUSED;
                    presc_d = {PW{1'b0}};
                    sec_d   = 8'd0;
                end
                ST_PAUSED: begin
                    if ((sec_q == SEC_LIMIT) && options[1]) begin
                        state_d = ST_DIMMED;
                    end else if (wrap_s) begin
                        presc_d = {PW{1'b0}};
                        if (sec_q < SEC_LIMIT) begin
                            sec_d = sec_q + 8'd1;
                        end else begin
                            sec_d = sec_q;
                        end
                    end else begin
                        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DIMMED: begin
                    if (!options[1]) begin
                        state_d = ST_PAUSED;
                    end else begin
                        state_d = ST_DIMMED;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    presc_d = {PW{1'b0}};
                    sec_d   = 8'd0;
                end
            endcase
        end
        dim_video_d = (state_d == ST_DIMMED);
    end

    // Video path, dimmed by the registered dim flag.
    always_comb begin
        if (dim_video_q) begin
            rgb_d = {r >> DIM_SHIFT, g >> DIM_SHIFT, b >> DIM_SHIFT};
        end else begin
            rgb_d = {r, g, b};
        end
    end

    // State registers; a button held through reset is treated as already high.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            btn_q        <= user_button;
            user_pause_q <= 1'b0;
            pause_cpu_q  <= 1'b0;
            dim_video_q  <= 1'b0;
            state_q      <= ST_RUN;
            presc_q      <= {PW{1'b0}};
            sec_q        <= 8'd0;
            rgb_q        <= {(RW+GW+BW){1'b0}};
        end else begin
            btn_q        <= btn_d;
            user_pause_q <= user_pause_d;
            pause_cpu_q  <= pause_cpu_d;
            dim_video_q  <= dim_video_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb_out   = rgb_q;
    assign pause_cpu = pause_cpu_q;
    assign dim_video = dim_video_q;

endmodule
